// File: rtl/ualink_dpmem_arbiter_pkg.sv
// Shared definitions for the dual-requester RAM port arbiter: FSM encoding and default sizes
// (also consumed by the dual_port_ram_8x64 integration).
package ualink_dpmem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_MAX_BURST  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ualink_rr_pick2.sv
// Two-way round-robin pick: a lone valid requester wins, a tie goes to the one rr points at.
module ualink_rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = i_rr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ualink_dpmem_arbiter.sv
// Arbitrates two command requesters onto RAM port A with lockable bursts and a
// one-cycle read response pipeline routed back to the requester that issued the read.
module ualink_dpmem_arbiter
  import ualink_dpmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output arb_state_t            o_dbg_state
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam bit            CAN_LOCK = (MAX_BURST > 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((MAX_BURST > 1) ? MAX_BURST - 2 : 0);

  arb_state_t            r_state;
  logic                  r_rr;
  logic [CW-1:0]         r_cnt;
  logic                  r_rsp_pend;
  logic                  r_rsp_own;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic [1:0]            w_pick;
  logic [1:0]            w_gnt;
  logic                  w_sel1;
  logic                  w_acc;
  logic                  w_we;
  logic                  w_lock;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  ualink_rr_pick2 u_pick (
    .i_valid (({req1_valid, req0_valid})),
    .i_rr    (r_rr),
    .o_grant (w_pick)
  );

  // Handshake: a beat transfers in a cycle where reqN_valid and reqN_ready are both high;
  // ready is combinational, never high for both requesters, and held low during reset.
  always_comb begin
    w_gnt = 2'b00;
    unique case (r_state)
      ST_IDLE: w_gnt = w_pick;
      ST_OWN0: w_gnt = {1'b0, req0_valid};
      ST_OWN1: w_gnt = {req1_valid, 1'b0};
      default: w_gnt = 2'b00;
    endcase
    if (!axi_resetn) begin
      w_gnt = 2'b00;
    end
  end

  assign w_sel1 = w_gnt[1];
  assign w_acc  = |w_gnt;
  assign w_we   = w_sel1 ? req1_we    : req0_we;
  assign w_lock = w_sel1 ? req1_lock  : req0_lock;
  assign w_addr = w_sel1 ? req1_addr  : req0_addr;
  assign w_din  = w_sel1 ? req1_wdata : req0_wdata;

  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign ram_we      = w_acc & w_we;
  assign ram_addr    = w_acc ? w_addr : r_addr;
  assign ram_din     = w_acc ? w_din  : r_din;
  assign o_dbg_state = r_state;

  // After a write, ram_dout returns the RAM's write-cycle value; only read-tagged cycles pass it.
  assign rsp0_valid = r_rsp_pend & ~r_rsp_own;
  assign rsp1_valid = r_rsp_pend &  r_rsp_own;
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state    <= ST_IDLE;
      r_rr       <= 1'b0;
      r_cnt      <= '0;
      r_rsp_pend <= 1'b0;
      r_rsp_own  <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
    end else begin
      r_rsp_pend <= w_acc & ~w_we;
      r_rsp_own  <= w_sel1;
      if (w_acc) begin
        r_rr   <= ~w_sel1;
        r_addr <= w_addr;
        r_din  <= w_din;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc && w_lock && CAN_LOCK) begin
            r_state <= w_sel1 ? ST_OWN1 : ST_OWN0;
            r_cnt   <= '0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // The entry beat was the first of the burst, so r_cnt lags the beat number by two.
          if (!w_acc || !w_lock || r_cnt == LAST_CNT) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
